// File: rtl/steer_pkg.sv
// Shared types and helpers for the steering quadrature sequencer.
package steer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSlow,
    StFast,
    StCenter
  } steer_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Gray-code stepping: right walks 00->01->11->10, left walks the reverse.
  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic step_dir);
    logic [1:0] nxt;
    nxt = phase;
    if (step_dir == DIR_RIGHT) begin
      case (phase)
        2'b00:   nxt = 2'b01;
        2'b01:   nxt = 2'b11;
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b00;
      endcase
    end else begin
      case (phase)
        2'b00:   nxt = 2'b10;
        2'b10:   nxt = 2'b11;
        2'b11:   nxt = 2'b01;
        default: nxt = 2'b00;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/steer_rate_div.sv
// Loadable down-counter setting the interval between quadrature steps.
// tick is high while the count sits at zero; the count holds at zero until reloaded.
module steer_rate_div #(
  parameter int unsigned Width = 8
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             tick
);

  logic [Width-1:0] cnt_q;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/steer_quad_seq.sv
// Sprint steering quadrature sequencer: turns left/right levels into a Gray-code
// SteerA/SteerB phase stepped slowly at first, then fast after a sustained hold.
// Optional auto-centering (CENTER state and net counter) is built when the
// STEER_CENTER_EN macro is defined.
module steer_quad_seq
  import steer_pkg::*;
#(
  parameter int unsigned CLKDIV_SLOW = 22500,
  parameter int unsigned CLKDIV_FAST = 7500,
  parameter int unsigned RAMP_STEPS  = 16
`ifdef STEER_CENTER_EN
  ,
  parameter int unsigned CENTER_MAX  = 64
`endif
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       enable,
  output logic [1:0] steer,
  output logic       step_pulse,
  output logic       dir,
  output logic       busy
);

  localparam int unsigned DivW  = $clog2(CLKDIV_SLOW);
  localparam int unsigned RampW = $clog2(RAMP_STEPS + 1);
  localparam logic [DivW-1:0] SlowLoad = DivW'(CLKDIV_SLOW - 1);
  localparam logic [DivW-1:0] FastLoad = DivW'(CLKDIV_FAST - 1);

  logic [1:0] left_sync_q, right_sync_q;
  logic       ls, rs, req, req_dir;

  steer_state_e     state_q, state_d;
  logic [RampW-1:0] ramp_q, ramp_d, ramp_sum;
  logic             do_step, step_dir, start, slow_step;
  logic             div_load, div_tick;
  logic [DivW-1:0]  div_value;

`ifdef STEER_CENTER_EN
  localparam int unsigned NetW = $clog2(CENTER_MAX + 1) + 1;
  localparam logic signed [NetW-1:0] NetOne    = NetW'(1);
  localparam logic signed [NetW-1:0] NetNegOne = -NetOne;
  localparam logic signed [NetW-1:0] NetMax    = NetW'(CENTER_MAX);
  localparam logic signed [NetW-1:0] NetMin    = -NetMax;

  logic signed [NetW-1:0] net_q;
`endif

  // Two-flop synchronisers for the asynchronous joystick levels.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      left_sync_q  <= '0;
      right_sync_q <= '0;
    end else begin
      left_sync_q  <= {left_sync_q[0], left};
      right_sync_q <= {right_sync_q[0], right};
    end
  end

  assign ls      = left_sync_q[1];
  assign rs      = right_sync_q[1];
  assign req     = enable & (ls ^ rs);
  assign req_dir = rs ? DIR_RIGHT : DIR_LEFT;

  steer_rate_div #(
    .Width (DivW)
  ) u_rate_div (
    .CLK   (CLK),
    .reset (reset),
    .load  (div_load),
    .value (div_value),
    .tick  (div_tick)
  );

  // Next-state decode: when to step, which way, and what the divider reloads with.
  always_comb begin
    state_d   = state_q;
    ramp_d    = ramp_q;
    ramp_sum  = '0;
    do_step   = 1'b0;
    step_dir  = dir;
    start     = 1'b0;
    slow_step = 1'b0;
    div_load  = 1'b0;
    div_value = '0;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          start = 1'b1;
`ifdef STEER_CENTER_EN
        end else if (enable && (net_q != '0)) begin
          state_d   = StCenter;
          div_load  = 1'b1;
          div_value = SlowLoad;
`endif
        end else begin
          div_load = 1'b1;
        end
      end
      StSlow, StFast: begin
        // Release beats a coincident divider expiry.
        if (!req) begin
          state_d  = StIdle;
          div_load = 1'b1;
          ramp_d   = '0;
        end else if (req_dir != dir) begin
          start = 1'b1;
        end else if (div_tick) begin
          do_step  = 1'b1;
          step_dir = dir;
          if (state_q == StSlow) begin
            slow_step = 1'b1;
            ramp_sum  = ramp_q + RampW'(1);
          end else begin
            div_load  = 1'b1;
            div_value = FastLoad;
          end
        end
      end
      StCenter: begin
`ifdef STEER_CENTER_EN
        if (req) begin
          start = 1'b1;
        end else if (!enable) begin
          state_d  = StIdle;
          div_load = 1'b1;
        end else if (div_tick) begin
          do_step   = 1'b1;
          step_dir  = net_q[NetW-1] ? DIR_RIGHT : DIR_LEFT;
          div_load  = 1'b1;
          div_value = SlowLoad;
          // Stepping toward zero from +/-1 lands centred.
          if ((net_q == NetOne) || (net_q == NetNegOne)) begin
            state_d = StIdle;
          end
        end
`else
        state_d  = StIdle;
        div_load = 1'b1;
`endif
      end
      default: begin
        state_d  = StIdle;
        div_load = 1'b1;
      end
    endcase

    // A fresh run steps immediately in the requested direction and counts as ramp step 1.
    if (start) begin
      do_step  = 1'b1;
      step_dir = req_dir;
      ramp_sum = RampW'(1);
    end

    if (start || slow_step) begin
      div_load = 1'b1;
      if (ramp_sum >= RampW'(RAMP_STEPS)) begin
        state_d   = StFast;
        div_value = FastLoad;
        ramp_d    = '0;
      end else begin
        state_d   = StSlow;
        div_value = SlowLoad;
        ramp_d    = ramp_sum;
      end
    end
  end

  // Sequencer state and registered outputs; step_pulse and dir land with the phase change.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ramp_q     <= '0;
      steer      <= 2'b00;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramp_q     <= ramp_d;
      step_pulse <= do_step;
      busy       <= (state_d != StIdle);
      if (do_step) begin
        steer <= next_phase(steer, step_dir);
        dir   <= step_dir;
      end
    end
  end

`ifdef STEER_CENTER_EN
  // Saturating net displacement: +1 per right step, -1 per left step.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      net_q <= '0;
    end else if (do_step) begin
      if (step_dir == DIR_RIGHT) begin
        if (net_q != NetMax) net_q <= net_q + NetOne;
      end else if (net_q != NetMin) begin
        net_q <= net_q - NetOne;
      end
    end
  end
`endif

endmodule

// File: tb/tb_steer_quad_seq.sv
// Directed bench for steer_quad_seq (CLKDIV_SLOW=8, CLKDIV_FAST=2, RAMP_STEPS=4, CENTER_MAX=3).
// Cycle c means sampled 1 time unit after the c-th rising edge following the stimulus change.
module tb_steer_quad_seq;

  logic       CLK = 1'b0;
  logic       reset, left, right, enable;
  logic [1:0] steer;
  logic       step_pulse, dir, busy;

  int errors = 0;
  int checks = 0;

  steer_quad_seq #(
    .CLKDIV_SLOW (8),
    .CLKDIV_FAST (2),
    .RAMP_STEPS  (4)
`ifdef STEER_CENTER_EN
    ,
    .CENTER_MAX  (3)
`endif
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .left       (left),
    .right      (right),
    .enable     (enable),
    .steer      (steer),
    .step_pulse (step_pulse),
    .dir        (dir),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    left   = 1'b0;
    right  = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    left   = 1'b0;
    right  = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({steer, step_pulse, busy, dir} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_hold: got %b want %b (steer,pulse,busy,dir)",
               {steer, step_pulse, busy, dir}, 5'b00000);
    end
    reset = 1'b0;
    right = 1'b1;
    repeat (3) next_cycle();
    checks++;
    if ({steer, step_pulse, busy, dir} !== 5'b01111) begin
      errors++;
      $display("FAIL reset_first_step: got %b want %b (steer,pulse,busy,dir)",
               {steer, step_pulse, busy, dir}, 5'b01111);
    end
    // Assert reset mid-pulse; outputs must clear without waiting for a clock edge.
    reset = 1'b1;
    #1;
    checks++;
    if ({steer, step_pulse, busy, dir} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_async: got %b want %b (steer,pulse,busy,dir)",
               {steer, step_pulse, busy, dir}, 5'b00000);
    end
    right = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      checks++;
      if ({steer, step_pulse, busy, dir} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: got %b want %b (steer,pulse,busy,dir)",
                 c, {steer, step_pulse, busy, dir}, 5'b00000);
      end
    end
  endtask

  // Hold right through SLOW and into FAST, then release on a divider-expiry cycle.
  task automatic test_right_hold();
    int         sc[7];
    logic [1:0] sv[7];
    int         cc[3];
    logic [1:0] cv[3];
    int         k, j, last;
    logic [1:0] es;
    logic       ep, eb, ed;
    sc = '{3, 11, 19, 27, 29, 31, 33};
    sv = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    cc = '{44, 52, 60};
    cv = '{2'b11, 2'b01, 2'b00};
`ifdef STEER_CENTER_EN
    last = 64;
`else
    last = 40;
`endif
    k = 0; j = 0; es = 2'b00; eb = 1'b0; ed = 1'b0;
    apply_reset();
    right = 1'b1;
    for (int c = 1; c <= last; c++) begin
      next_cycle();
      ep = 1'b0;
      if (k < 7 && c == sc[k]) begin
        es = sv[k]; ep = 1'b1; eb = 1'b1; ed = 1'b1; k++;
      end
      if (c == 35) eb = 1'b0;
`ifdef STEER_CENTER_EN
      // Seven right steps saturate net at +3; centering walks back three left steps.
      if (c == 36) eb = 1'b1;
      if (j < 3 && c == cc[j]) begin
        es = cv[j]; ep = 1'b1; ed = 1'b0; j++;
      end
      if (c == 60) eb = 1'b0;
`endif
      checks++;
      if ({steer, step_pulse, busy, dir} !== {es, ep, eb, ed}) begin
        errors++;
        $display("FAIL right_hold cyc=%0d: got %b want %b (steer,pulse,busy,dir)",
                 c, {steer, step_pulse, busy, dir}, {es, ep, eb, ed});
      end
      if (c == 32) right = 1'b0;
    end
  endtask

  // Both pressed is no request; dropping left leaves a right request.
  task automatic test_both_pressed();
    logic [1:0] es;
    logic       ep, eb, ed;
    es = 2'b00; eb = 1'b0; ed = 1'b0;
    apply_reset();
    left  = 1'b1;
    right = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      ep = 1'b0;
      if (c == 11) begin
        es = 2'b01; ep = 1'b1; eb = 1'b1; ed = 1'b1;
      end
      checks++;
      if ({steer, step_pulse, busy, dir} !== {es, ep, eb, ed}) begin
        errors++;
        $display("FAIL both_pressed cyc=%0d: got %b want %b (steer,pulse,busy,dir)",
                 c, {steer, step_pulse, busy, dir}, {es, ep, eb, ed});
      end
      if (c == 8) left = 1'b0;
    end
  endtask

  // Two right steps, then swap to left: immediate reverse step, ramp restarts from 1.
  task automatic test_reversal();
    int         sc[7];
    logic [1:0] sv[7];
    logic       sd[7];
    int         k;
    logic [1:0] es;
    logic       ep, eb, ed;
    sc = '{3, 11, 15, 23, 31, 39, 41};
    sv = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    sd = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    k = 0; es = 2'b00; eb = 1'b0; ed = 1'b0;
    apply_reset();
    right = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      next_cycle();
      ep = 1'b0;
      if (k < 7 && c == sc[k]) begin
        es = sv[k]; ep = 1'b1; eb = 1'b1; ed = sd[k]; k++;
      end
      checks++;
      if ({steer, step_pulse, busy, dir} !== {es, ep, eb, ed}) begin
        errors++;
        $display("FAIL reversal cyc=%0d: got %b want %b (steer,pulse,busy,dir)",
                 c, {steer, step_pulse, busy, dir}, {es, ep, eb, ed});
      end
      if (c == 12) begin
        right = 1'b0;
        left  = 1'b1;
      end
    end
  endtask

  // enable=0 during FAST on an expiry cycle freezes the phase; re-enable after release.
  task automatic test_enable_off();
    int         sc[5];
    logic [1:0] sv[5];
    int         cc[3];
    logic [1:0] cv[3];
    int         k, j, last;
    logic [1:0] es;
    logic       ep, eb, ed;
    sc = '{3, 11, 19, 27, 29};
    sv = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    cc = '{52, 60, 68};
    cv = '{2'b00, 2'b10, 2'b11};
`ifdef STEER_CENTER_EN
    last = 72;
`else
    last = 50;
`endif
    k = 0; j = 0; es = 2'b00; eb = 1'b0; ed = 1'b0;
    apply_reset();
    right = 1'b1;
    for (int c = 1; c <= last; c++) begin
      next_cycle();
      ep = 1'b0;
      if (k < 5 && c == sc[k]) begin
        es = sv[k]; ep = 1'b1; eb = 1'b1; ed = 1'b1; k++;
      end
      if (c == 31) eb = 1'b0;
`ifdef STEER_CENTER_EN
      // Five right steps saturate net at +3; centering starts once enable returns.
      if (c == 44) eb = 1'b1;
      if (j < 3 && c == cc[j]) begin
        es = cv[j]; ep = 1'b1; ed = 1'b0; j++;
      end
      if (c == 68) eb = 1'b0;
`endif
      checks++;
      if ({steer, step_pulse, busy, dir} !== {es, ep, eb, ed}) begin
        errors++;
        $display("FAIL enable_off cyc=%0d: got %b want %b (steer,pulse,busy,dir)",
                 c, {steer, step_pulse, busy, dir}, {es, ep, eb, ed});
      end
      if (c == 30) enable = 1'b0;
      if (c == 40) right = 1'b0;
      if (c == 43) enable = 1'b1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    left   = 1'b0;
    right  = 1'b0;
    enable = 1'b1;
    test_reset();
    test_right_hold();
    test_both_pressed();
    test_reversal();
    test_enable_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
